device_mailbox: RTL and testbench
=================================

Name: device_mailbox

Overview:
Memory-mapped inter-core mailbox that sits on the cluster's device bus, in the 0xFC00–0xFFFF remote address window. The cluster drives requests through device_* signals; this block is the responder.
- Cores push 16-bit messages into a shared FIFO and pop them out.
- Each entry is tagged with the ID of the sending core.
- The block also exposes status, requester ID, a free-running cycle counter and an overflow counter.
- Read data is registered, so it is valid the cycle after device_read_en, which matches the cluster's one-cycle read return.

Parameters:
BASE_ADDR, 10'h000, device_addr base of the 8-word register window; bits [2:0] are ignored.
FIFO_DEPTH, 8, number of mailbox entries; must be a power of two, 2..64.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset; sampled on posedge clk
device_core_id  input  3  ID of the core owning the current bus cycle
device_write_en  input  1  write strobe, one cycle
device_read_en  input  1  read strobe, one cycle
device_addr  input  10  word address within device space
device_data_out  input  16  write data from the cluster
device_data_in  output  16  read data to the cluster; valid the cycle after device_read_en
irq_not_empty  output  1  high while the FIFO holds at least one entry

Behaviour:
- Select: sel = (device_addr[9:3] == BASE_ADDR[9:3]). Register offset = device_addr[2:0].
- Register map, R = read, W = write:
  - 0 DATA. W pushes {device_core_id, device_data_out}. R returns the head data and pops it.
  - 1 STATUS (R). Returns {8'b0, count[6:0], full}. count is zero-extended; empty is count==0.
  - 2 REQ_ID (R). Returns {13'b0, device_core_id} as sampled at the read cycle.
  - 3 CYCLE (R). Returns the 16-bit free-running counter, +1 every clock, wraps 0xFFFF->0.
  - 4 SENDER (R). Returns {13'b0, head sender ID}. No pop; returns 0 when the FIFO is empty.
  - 5 OVERFLOW. R returns the saturating drop count (holds at 0xFFFF). W of any value clears it to 0.
  - 6, 7 reserved. Reads return 0; writes are ignored.
  - Writes to read-only offsets are ignored.
- Read timing:
  - device_data_in is registered. The value for a read in cycle N appears in N+1.
  - Otherwise device_data_in = 0, so device outputs can be OR-combined at cluster level.
  - This applies to unselected reads and to any cycle without a read.
- Push:
  - When not full: store the entry at wr_ptr, then wr_ptr+1 mod FIFO_DEPTH and count+1.
  - When full: drop the data and increment OVERFLOW, saturating.
- Pop:
  - When not empty: return the entry at rd_ptr, then rd_ptr+1 and count-1.
  - When empty: return 0x0000 with no state change.
- Simultaneous write and read in one cycle (illegal on the bus, but defined here):
  - The write is performed.
  - The read does not pop, and device_data_in = 0 in the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is a separate 7-bit counter. full = (count == FIFO_DEPTH).
- irq_not_empty is registered: it equals (count != 0) after the update of the same edge.
- Reset (reset==0 at posedge), mid-operation included:
  - Values: wr_ptr=rd_ptr=count=0, OVERFLOW=0, CYCLE=0, device_data_in=0, irq_not_empty=0.
  - FIFO storage contents are not reset.
  - Any strobe present during a reset cycle is ignored.

Test Plan:
1. Reset, then core 3 writes 0x1234 to DATA; read STATUS -> 0x0002 (count=1). Read SENDER -> 0x0003. Read DATA -> 0x1234 in the next cycle; STATUS -> 0x0000; irq_not_empty 1 then 0.
2. Fill 8 entries 0x0000..0x0007, then write 0xBEEF: STATUS -> 0x0011 (count=8, full), OVERFLOW -> 1. Pop 8 -> 0x0000..0x0007 in order; a 9th pop -> 0x0000.
3. Wrap: push 5, pop 5, push 8, pop 8 -> data in order, pointers wrapped, no overflow. Write OVERFLOW -> reads back 0.
4. Read with device_addr outside the window (BASE_ADDR 10'h040, addr 10'h000) -> device_data_in 0 and FIFO unchanged. Read REQ_ID from core 6 -> 0x0006.
5. CYCLE read at cycles N and N+10 -> difference of 10. Force the counter near 0xFFFF -> wraps to 0.
6. Assert reset low with 4 entries queued and a read in flight -> next cycle device_data_in=0, STATUS=0, irq_not_empty=0. The first pop after reset -> 0x0000.

Source files
------------

// File: rtl/device_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : device_mailbox
//  Purpose  : Memory-mapped inter-core mailbox on the cluster device bus.
//             Cores push 16-bit messages into a shared FIFO. Each message is
//             tagged with the sender's core ID. Cores pop messages back out.
//             The block also exposes status, the requester ID, a
//             free-running cycle counter and a saturating overflow counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1  clock
//    reset           in   1  synchronous active-low reset
//    device_core_id  in   3  ID of the core owning the current bus cycle
//    device_write_en in   1  write strobe (one cycle)
//    device_read_en  in   1  read strobe (one cycle)
//    device_addr     in  10  word address; [9:3] select, [2:0] register
//    device_data_out in  16  write data from the cluster
//    device_data_in  out 16  registered read data, valid the cycle after
//                            the read; 0 otherwise (OR-combinable)
//    irq_not_empty   out  1  registered, high while the FIFO is not empty
// ----------------------------------------------------------------------------
//  Register map (word offsets)
//    0 DATA     W push {core_id, data} / R pop head data
//    1 STATUS   R {8'b0, count[6:0], full}
//    2 REQ_ID   R {13'b0, device_core_id}
//    3 CYCLE    R free-running 16-bit counter
//    4 SENDER   R {13'b0, head sender ID}, 0 when empty, no pop
//    5 OVERFLOW R saturating drop count / W clears
//    6,7        reserved, read 0
// ============================================================================
module device_mailbox #(
  parameter logic [9:0]  BASE_ADDR  = 10'h000,
  parameter int unsigned FIFO_DEPTH = 8          // power of two, 2..64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  device_core_id,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        irq_not_empty
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned       C_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
  localparam logic [6:0]        C_DEPTH   = 7'(FIFO_DEPTH);
  localparam int unsigned       C_ENTRY_W = 19;  // {sender[2:0], data[15:0]}

  localparam logic [2:0] C_OFF_DATA   = 3'd0;
  localparam logic [2:0] C_OFF_STATUS = 3'd1;
  localparam logic [2:0] C_OFF_REQID  = 3'd2;
  localparam logic [2:0] C_OFF_CYCLE  = 3'd3;
  localparam logic [2:0] C_OFF_SENDER = 3'd4;
  localparam logic [2:0] C_OFF_OVF    = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]         count_q,  count_d;
  logic [15:0]        ovf_q,    ovf_d;
  logic [15:0]        cycle_q,  cycle_d;
  logic [15:0]        rdata_q,  rdata_d;
  logic               irq_q,    irq_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic                 w_sel;
  logic [2:0]           w_off;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_empty;
  logic                 w_full;
  logic [C_ENTRY_W-1:0] w_head;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_ovf_clr;
  logic [15:0]          w_rd_mux;

  always_comb begin
    w_sel   = (device_addr[9:3] == BASE_ADDR[9:3]);
    w_off   = device_addr[2:0];
    w_wr    = w_sel & device_write_en;
    // A read that collides with a write is discarded: no pop, zero return.
    w_rd    = w_sel & device_read_en & ~device_write_en;
    w_empty = (count_q == 7'd0);
    w_full  = (count_q == C_DEPTH);
    w_head  = mem_q[rd_ptr_q];

    w_push    = w_wr & (w_off == C_OFF_DATA) & ~w_full;
    w_drop    = w_wr & (w_off == C_OFF_DATA) &  w_full;
    w_pop     = w_rd & (w_off == C_OFF_DATA) & ~w_empty;
    w_ovf_clr = w_wr & (w_off == C_OFF_OVF);
  end

  // --------------------------------------------------------------------------
  // Read data multiplexer (value presented for the current cycle's read)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = 16'h0000;
    case (w_off)
      C_OFF_DATA:   w_rd_mux = w_empty ? 16'h0000 : w_head[15:0];
      C_OFF_STATUS: w_rd_mux = {8'h00, count_q, w_full};
      C_OFF_REQID:  w_rd_mux = {13'h0000, device_core_id};
      C_OFF_CYCLE:  w_rd_mux = cycle_q;
      C_OFF_SENDER: w_rd_mux = w_empty ? 16'h0000 : {13'h0000, w_head[18:16]};
      C_OFF_OVF:    w_rd_mux = ovf_q;
      default:      w_rd_mux = 16'h0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cycle_d  = cycle_q + 16'd1;

    // Push and pop are mutually exclusive: a single cycle addresses one
    // register and a read is dropped whenever a write is present.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      count_d  = count_q + 7'd1;
    end else if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      count_d  = count_q - 7'd1;
    end

    if (w_ovf_clr) begin
      ovf_d = 16'h0000;
    end else if (w_drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    rdata_d = w_rd ? w_rd_mux : 16'h0000;
    // The interrupt reflects the count as updated on this same edge.
    irq_d   = (count_d != 7'd0);
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 7'd0;
      ovf_q    <= 16'h0000;
      cycle_q  <= 16'h0000;
      rdata_q  <= 16'h0000;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage: not reset; writes are blocked while reset is asserted so a
  // strobe coinciding with reset leaves no trace.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      mem_q[wr_ptr_q] <= {device_core_id, device_data_out};
    end
  end

  assign device_data_in = rdata_q;
  assign irq_not_empty  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_device_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_device_mailbox
//  Purpose  : Self-checking bench for device_mailbox. A queue-based model of
//             the mailbox predicts device_data_in and irq_not_empty on every
//             cycle; directed steps additionally compare against constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_device_mailbox;

  localparam logic [9:0]  BASE  = 10'h040;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  device_core_id;
  logic        device_write_en;
  logic        device_read_en;
  logic [9:0]  device_addr;
  logic [15:0] device_data_out;
  logic [15:0] device_data_in;
  logic        irq_not_empty;

  device_mailbox #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in),
    .irq_not_empty   (irq_not_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of {sender, data}, plain counters.
  // --------------------------------------------------------------------------
  logic [18:0] mq[$];
  int          m_ovf   = 0;
  int          m_cyc   = 0;
  logic [15:0] m_out   = 16'h0;
  logic        m_irq   = 1'b0;

  task automatic model_step(input logic we, input logic re, input logic [9:0] a,
                            input logic [2:0] id, input logic [15:0] d, input logic rn);
    logic       sel;
    logic [2:0] off;
    int         sz;
    if (!rn) begin
      mq.delete();
      m_ovf = 0;
      m_cyc = 0;
      m_out = 16'h0;
      m_irq = 1'b0;
      return;
    end
    sel   = (a[9:3] == BASE[9:3]);
    off   = a[2:0];
    sz    = mq.size();
    m_out = 16'h0;
    if (sel && re && !we) begin
      case (off)
        3'd0: if (sz > 0) m_out = mq.pop_front() & 19'h0FFFF;
        3'd1: m_out = 16'(sz * 2 + ((sz == DEPTH) ? 1 : 0));
        3'd2: m_out = 16'(id);
        3'd3: m_out = 16'(m_cyc);
        3'd4: if (sz > 0) m_out = 16'(mq[0] >> 16);
        3'd5: m_out = 16'(m_ovf);
        default: m_out = 16'h0;
      endcase
    end
    if (sel && we) begin
      if (off == 3'd0) begin
        if (sz < DEPTH) mq.push_back({id, d});
        else if (m_ovf < 65535) m_ovf++;
      end else if (off == 3'd5) begin
        m_ovf = 0;
      end
    end
    m_cyc = (m_cyc + 1) % 65536;
    m_irq = (mq.size() != 0);
  endtask

  // One bus cycle: drive, clock, update model, check both outputs.
  task automatic bus(input logic we, input logic re, input logic [9:0] a,
                     input logic [2:0] id, input logic [15:0] d, input logic rn);
    reset           = rn;
    device_write_en = we;
    device_read_en  = re;
    device_addr     = a;
    device_core_id  = id;
    device_data_out = d;
    @(posedge clk);
    model_step(we, re, a, id, d, rn);
    #1;
    chk_eq("dout", device_data_in, m_out);
    chk_eq("irq", irq_not_empty, m_irq);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 10'h000, 3'd0, 16'h0, 1'b1);
  endtask

  task automatic wr(input logic [2:0] off, input logic [2:0] id, input logic [15:0] d);
    bus(1'b1, 1'b0, {BASE[9:3], off}, id, d, 1'b1);
  endtask

  task automatic rd(input logic [2:0] off, input logic [2:0] id, output logic [15:0] v);
    bus(1'b0, 1'b1, {BASE[9:3], off}, id, 16'h0, 1'b1);
    v = device_data_in;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] c0;
    logic        we, re, rn;
    logic [9:0]  a;
    int          guard;

    // Reset
    for (int i = 0; i < 3; i++) bus(1'b0, 1'b0, 10'h000, 3'd0, 16'h0, 1'b0);
    chk_eq("rst_dout", device_data_in, 16'h0);
    chk_eq("rst_irq", irq_not_empty, 1'b0);

    // 1: single message round trip
    wr(3'd0, 3'd3, 16'h1234);
    chk_eq("t1_irq_set", irq_not_empty, 1'b1);
    rd(3'd1, 3'd0, v);  chk_eq("t1_status", v, 16'h0002);
    rd(3'd4, 3'd0, v);  chk_eq("t1_sender", v, 16'h0003);
    rd(3'd0, 3'd0, v);  chk_eq("t1_data", v, 16'h1234);
    chk_eq("t1_irq_clr", irq_not_empty, 1'b0);
    rd(3'd1, 3'd0, v);  chk_eq("t1_status_empty", v, 16'h0000);

    // 2: fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) wr(3'd0, 3'(i), 16'(i));
    wr(3'd0, 3'd1, 16'hBEEF);
    rd(3'd1, 3'd0, v);  chk_eq("t2_status_full", v, 16'h0011);
    rd(3'd5, 3'd0, v);  chk_eq("t2_ovf", v, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      rd(3'd0, 3'd0, v); chk_eq("t2_pop", v, 16'(i));
    end
    rd(3'd0, 3'd0, v);  chk_eq("t2_pop_empty", v, 16'h0000);

    // 3: pointer wrap, then overflow clear
    for (int i = 0; i < 5; i++) wr(3'd0, 3'd2, 16'h0100 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      rd(3'd0, 3'd0, v); chk_eq("t3_pop5", v, 16'h0100 + 16'(i));
    end
    for (int i = 0; i < 8; i++) wr(3'd0, 3'd5, 16'h0200 + 16'(i));
    rd(3'd1, 3'd0, v);  chk_eq("t3_status_full", v, 16'h0011);
    for (int i = 0; i < 8; i++) begin
      rd(3'd0, 3'd0, v); chk_eq("t3_pop8", v, 16'h0200 + 16'(i));
    end
    rd(3'd5, 3'd0, v);  chk_eq("t3_ovf_kept", v, 16'h0001);
    wr(3'd5, 3'd0, 16'hFFFF);
    rd(3'd5, 3'd0, v);  chk_eq("t3_ovf_clr", v, 16'h0000);

    // 4: out-of-window access, REQ_ID, reserved, collision
    wr(3'd0, 3'd4, 16'hA5A5);
    bus(1'b0, 1'b1, 10'h000, 3'd0, 16'h0, 1'b1);
    chk_eq("t4_unsel_rd", device_data_in, 16'h0000);
    bus(1'b1, 1'b0, 10'h000, 3'd0, 16'h7777, 1'b1);
    rd(3'd1, 3'd0, v);  chk_eq("t4_status", v, 16'h0002);
    rd(3'd2, 3'd6, v);  chk_eq("t4_reqid", v, 16'h0006);
    rd(3'd6, 3'd0, v);  chk_eq("t4_reserved", v, 16'h0000);
    bus(1'b1, 1'b1, {BASE[9:3], 3'd0}, 3'd1, 16'h5A5A, 1'b1);
    chk_eq("t4_collide", device_data_in, 16'h0000);
    rd(3'd0, 3'd0, v);  chk_eq("t4_pop_a", v, 16'hA5A5);
    rd(3'd0, 3'd0, v);  chk_eq("t4_pop_b", v, 16'h5A5A);

    // Randomized traffic, including occasional resets and collisions
    for (int i = 0; i < 1500; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) a = 10'($urandom);
      else if ($urandom_range(0, 1) == 0) a = {BASE[9:3], 3'd0};
      else a = {BASE[9:3], 3'($urandom_range(0, 7))};
      bus(we, re, a, 3'($urandom), 16'($urandom), rn);
    end

    // 6: reset with entries queued and a read in flight
    bus(1'b0, 1'b0, 10'h000, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) wr(3'd0, 3'd7, 16'hC000 + 16'(i));
    rd(3'd0, 3'd0, v);  chk_eq("t6_inflight", v, 16'hC000);
    bus(1'b0, 1'b1, {BASE[9:3], 3'd0}, 3'd0, 16'h0, 1'b0);
    chk_eq("t6_rst_dout", device_data_in, 16'h0000);
    chk_eq("t6_rst_irq", irq_not_empty, 1'b0);
    rd(3'd1, 3'd0, v);  chk_eq("t6_status", v, 16'h0000);
    rd(3'd0, 3'd0, v);  chk_eq("t6_pop", v, 16'h0000);

    // 5: cycle counter distance and wrap
    rd(3'd3, 3'd0, c0);
    for (int i = 0; i < 9; i++) idle();
    rd(3'd3, 3'd0, v);  chk_eq("t5_delta", v - c0, 16'd10);
    guard = 0;
    while (m_cyc != 16'hFFFE && guard < 70000) begin
      idle();
      guard++;
    end
    chk_eq("t5_reach", 32'(m_cyc), 32'hFFFE);
    rd(3'd3, 3'd0, v);  chk_eq("t5_fffe", v, 16'hFFFE);
    rd(3'd3, 3'd0, v);  chk_eq("t5_ffff", v, 16'hFFFF);
    rd(3'd3, 3'd0, v);  chk_eq("t5_wrap", v, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
